// File: rtl/spi_read_arbiter_if.sv
// Requester-side bus of the SPI read arbiter: two request lines, two command words,
// grant/valid pulses and the shared read-data word.
interface spi_read_arbiter_if #(
  parameter int unsigned DATA_W = 16
);
  logic [1:0]        req_i;
  logic [DATA_W-1:0] cmd0_i;
  logic [DATA_W-1:0] cmd1_i;
  logic [1:0]        gnt_o;
  logic              busy_o;
  logic [DATA_W-1:0] rdata_o;
  logic [1:0]        rvalid_o;

  // Arbiter side
  modport slave (
    input  req_i, cmd0_i, cmd1_i,
    output gnt_o, busy_o, rdata_o, rvalid_o
  );

  // Requester side
  modport master (
    output req_i, cmd0_i, cmd1_i,
    input  gnt_o, busy_o, rdata_o, rvalid_o
  );
endinterface

// File: rtl/spi_read_arbiter.sv
// Two-requester round-robin arbiter in front of a mode-0 SPI master. Each granted
// request runs one full-duplex transfer: the command word goes out on mosi, the
// word shifted in on miso is returned on rdata with a one-hot rvalid pulse.
module spi_read_arbiter #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned SCLK_HALF = 2,
  parameter int unsigned CS_GAP    = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  spi_read_arbiter_if.slave bus,
  output logic              cs_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i
);
  localparam int unsigned HalfW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int unsigned BitW  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned GapW  = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [HalfW-1:0] HalfLast = HalfW'(SCLK_HALF - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_W - 1);
  localparam logic [GapW-1:0]  GapLast  = GapW'(CS_GAP - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StDone, StGap} state_e;

  state_e            state_q, state_d;
  logic [HalfW-1:0]  half_q, half_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic              owner_q, owner_d;  // requester being served
  logic              last_q, last_d;    // requester served most recently
  logic              cs_q, cs_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              busy_q, busy_d;
  logic              win;
  logic [1:0]        gnt;

  // Round-robin pick; grant only in IDLE and never while reset is being applied
  always_comb begin
    win = (bus.req_i == 2'b11) ? ~last_q : bus.req_i[1];
    gnt = 2'b00;
    if (state_q == StIdle && !rst_i && bus.req_i != 2'b00) begin
      gnt = win ? 2'b10 : 2'b01;
    end
  end

  // Next-state logic; pin outputs are computed from the next state so they are registered
  always_comb begin
    state_d  = state_q;
    half_d   = half_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    rdata_d  = rdata_q;
    rvalid_d = 2'b00;
    owner_d  = owner_q;
    last_d   = last_q;
    cs_d     = cs_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    busy_d   = busy_q;
    case (state_q)
      StIdle: begin
        if (gnt != 2'b00) begin
          state_d = StSetup;
          owner_d = win;
          last_d  = win;
          tx_d    = win ? bus.cmd1_i : bus.cmd0_i;
          rx_d    = '0;
          half_d  = '0;
          bit_d   = '0;
          cs_d    = 1'b0;
          sclk_d  = 1'b0;
          mosi_d  = tx_d[DATA_W-1];
          busy_d  = 1'b1;
        end
      end
      StSetup: begin
        if (half_q == HalfLast) begin
          half_d  = '0;
          sclk_d  = 1'b1;
          state_d = StShift;
        end else begin
          half_d = half_q + 1'b1;
        end
      end
      StShift: begin
        // Capture miso during the first clk cycle of each sclk high phase
        if (sclk_q && half_q == '0) begin
          rx_d = {rx_q[DATA_W-2:0], miso_i};
        end
        if (half_q != HalfLast) begin
          half_d = half_q + 1'b1;
        end else begin
          half_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            tx_d   = tx_q << 1;
            mosi_d = (bit_q == BitLast) ? 1'b0 : tx_d[DATA_W-1];
          end else if (bit_q == BitLast) begin
            state_d  = StDone;
            bit_d    = '0;
            cs_d     = 1'b1;
            rdata_d  = rx_q;
            rvalid_d = owner_q ? 2'b10 : 2'b01;
          end else begin
            bit_d  = bit_q + 1'b1;
            sclk_d = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StGap;
        gap_d   = '0;
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset; reset aborts any transfer silently
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      half_q   <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 2'b00;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      half_q   <= half_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cs_q     <= cs_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.gnt_o    = gnt;
  assign bus.busy_o   = busy_q;
  assign bus.rdata_o  = rdata_q;
  assign bus.rvalid_o = rvalid_q;
  assign cs_o         = cs_q;
  assign sclk_o       = sclk_q;
  assign mosi_o       = mosi_q;
endmodule
